i2c_mem_arbiter: RTL and testbench

Shares the single-port backing memory between the I2C subordinate datapath (`memory_interface` side) and a local host port on `CLOCK_50`. It sequences one memory access per grant and returns read data with a valid pulse. It also watches I2C service latency, because the subordinate does not stretch SCL and cannot stall. The block sits between both requesters and the memory macro, entirely in the `clk` domain; I2C-side requests arrive already synchronized.

---
 rtl/i2c_mem_arb_pkg.sv | 22 ++
 rtl/i2c_mem_arbiter_pick.sv | 43 ++++
 rtl/i2c_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_i2c_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_mem_arb_pkg.sv
// Shared types for the I2C / host memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT_RD)
//   arb_owner_t : grantee encoding (OWN_I2C = 0, OWN_HOST = 1)
//   RD_LAT_MAX  : largest supported memory read latency
//   LAT_CNT_W   : width of the read-latency down-counter
package i2c_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I2C  = 1'b0,
        OWN_HOST = 1'b1
    } arb_owner_t;

    localparam int RD_LAT_MAX = 4;
    localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/i2c_mem_arbiter_pick.sv
// Combinational winner selection between the I2C and host requesters.
// Configuration macro: I2C_MEM_ARB_RR_EN (round-robin when defined,
// fixed I2C-over-host priority otherwise).
// Ports:
//   i2c_req_i  : I2C request level
//   host_req_i : host request level
//   last_i     : requester granted most recently
//   any_o      : at least one request present
//   win_o      : selected requester (only meaningful when any_o = 1)
module arb_pick
    import i2c_mem_arb_pkg::*;
(
    input  logic       i2c_req_i,
    input  logic       host_req_i,
    input  arb_owner_t last_i,
    output logic       any_o,
    output arb_owner_t win_o
);

`ifndef I2C_MEM_ARB_RR_EN
    // Fixed priority never looks at history.
    logic unused_last;
    assign unused_last = last_i;
`endif

    always_comb begin
        any_o = i2c_req_i | host_req_i;
        win_o = OWN_I2C;
`ifdef I2C_MEM_ARB_RR_EN
        if (i2c_req_i && host_req_i) begin
            // Tie: whoever was not served last goes first.
            win_o = (last_i == OWN_I2C) ? OWN_HOST : OWN_I2C;
        end else if (host_req_i) begin
            win_o = OWN_HOST;
        end
`else
        if (!i2c_req_i && host_req_i) begin
            win_o = OWN_HOST;
        end
`endif
    end

endmodule

// File: rtl/i2c_mem_arbiter.sv
// Arbiter sharing a single-port memory between the I2C subordinate datapath
// and a local host port. One memory access per grant; read data is returned
// with a one-cycle valid pulse. Also flags I2C requests that wait too long,
// since the I2C side cannot stretch SCL.
// Configuration macro: I2C_MEM_ARB_RR_EN (round-robin tie break in arb_pick).
// Ports:
//   clk_i, rst_n_i                    : clock, async active-low reset
//   i2c_req_i/we_i/addr_i/wdata_i     : I2C request (level, held until grant)
//   i2c_gnt_o, i2c_rvalid_o, i2c_rdata_o : I2C grant pulse, read valid, read data
//   host_*                            : host-side equivalents
//   mem_en_o/we_o/addr_o/wdata_o      : memory strobe and access fields
//   mem_rdata_i                       : memory read data (RD_LAT after mem_en_o)
//   busy_o                            : FSM not in IDLE
//   owner_o                           : current / last grantee (0 = I2C)
//   i2c_overrun_o, overrun_clr_i      : sticky I2C latency violation and its clear
module i2c_mem_arbiter
    import i2c_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int RD_LAT       = 1,
    parameter int I2C_MAX_WAIT = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              i2c_req_i,
    input  logic              i2c_we_i,
    input  logic [ADDR_W-1:0] i2c_addr_i,
    input  logic [DATA_W-1:0] i2c_wdata_i,
    output logic              i2c_gnt_o,
    output logic              i2c_rvalid_o,
    output logic [DATA_W-1:0] i2c_rdata_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o,
    output logic              i2c_overrun_o,
    input  logic              overrun_clr_i
);

    localparam int                    WAIT_W   = $clog2(I2C_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_MAX = WAIT_W'(I2C_MAX_WAIT);
    localparam logic [LAT_CNT_W-1:0]  LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

    arb_state_t             state_q, state_d;
    arb_owner_t             owner_q, owner_d;
    arb_owner_t             last_q, last_d;
    logic [LAT_CNT_W-1:0]   lat_q, lat_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]      i2c_rdata_q, i2c_rdata_d;
    logic [DATA_W-1:0]      host_rdata_q, host_rdata_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   ovr_q, ovr_d;

    logic                   any_req;
    arb_owner_t             win;
    logic                   rd_done;

    arb_pick u_pick (
        .i2c_req_i  (i2c_req_i),
        .host_req_i (host_req_i),
        .last_i     (last_q),
        .any_o      (any_req),
        .win_o      (win)
    );

    // Last WAIT_RD cycle: mem_rdata_i is valid right now.
    assign rd_done = (state_q == WAIT_RD) && (lat_q == '0);

    assign mem_en_o      = (state_q == ISSUE);
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign i2c_gnt_o     = (state_q == ISSUE) && (owner_q == OWN_I2C);
    assign host_gnt_o    = (state_q == ISSUE) && (owner_q == OWN_HOST);
    assign i2c_rvalid_o  = rd_done && (owner_q == OWN_I2C);
    assign host_rvalid_o = rd_done && (owner_q == OWN_HOST);
    // During the valid pulse the memory data is forwarded so rdata lines up
    // with rvalid; the register then holds it until the next read completes.
    assign i2c_rdata_o   = i2c_rvalid_o  ? mem_rdata_i : i2c_rdata_q;
    assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : host_rdata_q;
    assign busy_o        = (state_q != IDLE);
    assign owner_o       = owner_q;
    assign i2c_overrun_o = ovr_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        lat_d        = lat_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i2c_rdata_d  = i2c_rdata_q;
        host_rdata_d = host_rdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d     = win;
                    last_d      = win;
                    mem_we_d    = (win == OWN_I2C) ? i2c_we_i    : host_we_i;
                    mem_addr_d  = (win == OWN_I2C) ? i2c_addr_i  : host_addr_i;
                    mem_wdata_d = (win == OWN_I2C) ? i2c_wdata_i : host_wdata_i;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    state_d = IDLE;
                end else begin
                    lat_d   = LAT_LOAD;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (lat_q == '0) begin
                    if (owner_q == OWN_I2C) i2c_rdata_d  = mem_rdata_i;
                    else                    host_rdata_d = mem_rdata_i;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - LAT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // I2C latency monitor: counts ungranted request cycles.
    always_comb begin
        wait_d = wait_q;
        ovr_d  = ovr_q;
        if (!i2c_req_i || i2c_gnt_o) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        // Set has priority over a coincident clear.
        if (wait_d == WAIT_MAX) begin
            ovr_d = 1'b1;
        end else if (overrun_clr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I2C;
            last_q       <= OWN_HOST;
            lat_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i2c_rdata_q  <= '0;
            host_rdata_q <= '0;
            wait_q       <= '0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            lat_q        <= lat_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i2c_rdata_q  <= i2c_rdata_d;
            host_rdata_q <= host_rdata_d;
            wait_q       <= wait_d;
            ovr_q        <= ovr_d;
        end
    end

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Testbench for i2c_mem_arbiter (RD_LAT = 2, I2C_MAX_WAIT = 4).
// Cycle table for the main traffic, then hand sequences for overrun,
// tie ordering and reset during a pending read.
module tb_i2c_mem_arbiter;

`ifdef I2C_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i2c_req, i2c_we, host_req, host_we, overrun_clr;
    logic [7:0] i2c_addr, i2c_wdata, host_addr, host_wdata;
    logic       i2c_gnt, i2c_rvalid, host_gnt, host_rvalid;
    logic [7:0] i2c_rdata, host_rdata;
    logic       mem_en, mem_we, busy, owner, i2c_overrun;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    i2c_mem_arbiter #(
        .ADDR_W(8), .DATA_W(8), .RD_LAT(2), .I2C_MAX_WAIT(4)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .i2c_req_i     (i2c_req),
        .i2c_we_i      (i2c_we),
        .i2c_addr_i    (i2c_addr),
        .i2c_wdata_i   (i2c_wdata),
        .i2c_gnt_o     (i2c_gnt),
        .i2c_rvalid_o  (i2c_rvalid),
        .i2c_rdata_o   (i2c_rdata),
        .host_req_i    (host_req),
        .host_we_i     (host_we),
        .host_addr_i   (host_addr),
        .host_wdata_i  (host_wdata),
        .host_gnt_o    (host_gnt),
        .host_rvalid_o (host_rvalid),
        .host_rdata_o  (host_rdata),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .busy_o        (busy),
        .owner_o       (owner),
        .i2c_overrun_o (i2c_overrun),
        .overrun_clr_i (overrun_clr)
    );

    // Memory model: read data = addr ^ 0x2E, valid exactly 2 cycles after
    // the mem_en cycle, zero otherwise.
    logic [7:0] p1, p2;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1 <= 8'h00;
            p2 <= 8'h00;
        end else begin
            p1 <= mem_en ? (mem_addr ^ 8'h2E) : 8'h00;
            p2 <= p1;
        end
    end
    assign mem_rdata = p2;

    typedef struct packed {
        logic       ireq; logic iwe; logic [7:0] iaddr; logic [7:0] iwd;
        logic       hreq; logic hwe; logic [7:0] haddr; logic [7:0] hwd;
    } in_t;

    typedef struct packed {
        logic       i2c_gnt; logic host_gnt; logic mem_en; logic mem_we;
        logic [7:0] mem_addr; logic [7:0] mem_wdata;
        logic       i2c_rv; logic [7:0] i2c_rd;
        logic       host_rv; logic [7:0] host_rd;
        logic       busy; logic owner; logic ovr;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic in_t I(logic ireq, logic iwe, logic [7:0] iaddr, logic [7:0] iwd,
                              logic hreq, logic hwe, logic [7:0] haddr, logic [7:0] hwd);
        return '{ireq, iwe, iaddr, iwd, hreq, hwe, haddr, hwd};
    endfunction

    function automatic out_t O(logic ig, logic hg, logic en, logic we,
                               logic [7:0] a, logic [7:0] wd,
                               logic irv, logic [7:0] ird, logic hrv, logic [7:0] hrd,
                               logic b, logic own, logic ovr);
        return '{ig, hg, en, we, a, wd, irv, ird, hrv, hrd, b, own, ovr};
    endfunction

    function automatic out_t sample();
        return '{i2c_gnt, host_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                 i2c_rvalid, i2c_rdata, host_rvalid, host_rdata,
                 busy, owner, i2c_overrun};
    endfunction

    task automatic drive(in_t v);
        i2c_req   = v.ireq;  i2c_we  = v.iwe;  i2c_addr  = v.iaddr; i2c_wdata  = v.iwd;
        host_req  = v.hreq;  host_we = v.hwe;  host_addr = v.haddr; host_wdata = v.hwd;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Main traffic table: inputs during a cycle, outputs seen in that cycle.
        tbl.push_back('{"idle",          I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00), O(0,0,0,0,8'h00,8'h00,0,8'h00,0,8'h00,0,0,0)});
        tbl.push_back('{"i2c_wr_req",    I(1,1,8'h12,8'hA5, 0,0,8'h00,8'h00), O(0,0,0,0,8'h00,8'h00,0,8'h00,0,8'h00,0,0,0)});
        tbl.push_back('{"i2c_wr_gnt",    I(1,1,8'h12,8'hA5, 0,0,8'h00,8'h00), O(1,0,1,1,8'h12,8'hA5,0,8'h00,0,8'h00,1,0,0)});
        tbl.push_back('{"i2c_wr_done",   I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00), O(0,0,0,1,8'h12,8'hA5,0,8'h00,0,8'h00,0,0,0)});
        tbl.push_back('{"host_rd_req",   I(0,0,8'h00,8'h00, 1,0,8'h12,8'h00), O(0,0,0,1,8'h12,8'hA5,0,8'h00,0,8'h00,0,0,0)});
        tbl.push_back('{"host_rd_gnt",   I(0,0,8'h00,8'h00, 1,0,8'h12,8'h00), O(0,1,1,0,8'h12,8'h00,0,8'h00,0,8'h00,1,1,0)});
        tbl.push_back('{"host_rd_wait",  I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00), O(0,0,0,0,8'h12,8'h00,0,8'h00,0,8'h00,1,1,0)});
        tbl.push_back('{"host_rd_valid", I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00), O(0,0,0,0,8'h12,8'h00,0,8'h00,1,8'h3C,1,1,0)});
        tbl.push_back('{"host_rd_hold",  I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00), O(0,0,0,0,8'h12,8'h00,0,8'h00,0,8'h3C,0,1,0)});
        tbl.push_back('{"tie_req",       I(1,0,8'h40,8'h00, 1,1,8'h55,8'h77), O(0,0,0,0,8'h12,8'h00,0,8'h00,0,8'h3C,0,1,0)});
        tbl.push_back('{"tie_gnt_i2c",   I(1,0,8'h40,8'h00, 1,1,8'h55,8'h77), O(1,0,1,0,8'h40,8'h00,0,8'h00,0,8'h3C,1,0,0)});
        tbl.push_back('{"i2c_rd_wait",   I(0,0,8'h00,8'h00, 1,1,8'h55,8'h77), O(0,0,0,0,8'h40,8'h00,0,8'h00,0,8'h3C,1,0,0)});
        tbl.push_back('{"i2c_rd_valid",  I(0,0,8'h00,8'h00, 1,1,8'h55,8'h77), O(0,0,0,0,8'h40,8'h00,1,8'h6E,0,8'h3C,1,0,0)});
        tbl.push_back('{"host_wr_req",   I(0,0,8'h00,8'h00, 1,1,8'h55,8'h77), O(0,0,0,0,8'h40,8'h00,0,8'h6E,0,8'h3C,0,0,0)});
        tbl.push_back('{"host_wr_gnt1",  I(0,0,8'h00,8'h00, 1,1,8'h55,8'h77), O(0,1,1,1,8'h55,8'h77,0,8'h6E,0,8'h3C,1,1,0)});
        tbl.push_back('{"host_wr_idle",  I(0,0,8'h00,8'h00, 1,1,8'h55,8'h77), O(0,0,0,1,8'h55,8'h77,0,8'h6E,0,8'h3C,0,1,0)});
        tbl.push_back('{"host_wr_gnt2",  I(0,0,8'h00,8'h00, 1,1,8'h55,8'h77), O(0,1,1,1,8'h55,8'h77,0,8'h6E,0,8'h3C,1,1,0)});
        tbl.push_back('{"host_wr_end",   I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00), O(0,0,0,1,8'h55,8'h77,0,8'h6E,0,8'h3C,0,1,0)});

        // Reset
        rst_n = 1'b0;
        overrun_clr = 1'b0;
        drive(I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00));
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'(sample()), 64'(0));
        next_cycle();
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].in);
            @(negedge clk);
            chk(tbl[k].name, 64'(sample()), 64'(tbl[k].exp));
            next_cycle();
        end

        // Overrun: I2C request arrives during a host read grant.
        drive(I(0,0,8'h00,8'h00, 1,0,8'h20,8'h00));
        @(negedge clk); next_cycle();
        drive(I(1,1,8'h30,8'h99, 1,0,8'h20,8'h00));
        @(negedge clk);
        chk("ovr_host_gnt", {62'd0, host_gnt, i2c_overrun}, 64'b10);
        next_cycle();
        drive(I(1,1,8'h30,8'h99, 0,0,8'h00,8'h00));
        @(negedge clk);
        chk("ovr_wait1", {62'd0, busy, i2c_overrun}, 64'b10);
        next_cycle();
        @(negedge clk);
        chk("ovr_host_rvalid", {54'd0, host_rvalid, host_rdata, i2c_overrun}, {54'd0, 1'b1, 8'h0E, 1'b0});
        next_cycle();
        overrun_clr = 1'b1;
        @(negedge clk);
        chk("ovr_idle_pre", {61'd0, busy, i2c_gnt, i2c_overrun}, 64'd0);
        next_cycle();
        overrun_clr = 1'b0;
        @(negedge clk);
        chk("ovr_set_wins", {45'd0, i2c_gnt, mem_we, mem_addr, mem_wdata, i2c_overrun},
            {45'd0, 1'b1, 1'b1, 8'h30, 8'h99, 1'b1});
        next_cycle();
        drive(I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00));
        @(negedge clk);
        chk("ovr_sticky", {63'd0, i2c_overrun}, 64'd1);
        next_cycle();
        overrun_clr = 1'b1;
        @(negedge clk);
        chk("ovr_hold_clr", {63'd0, i2c_overrun}, 64'd1);
        next_cycle();
        overrun_clr = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", {63'd0, i2c_overrun}, 64'd0);
        next_cycle();

        // Tie right after an I2C grant.
        drive(I(1,1,8'h01,8'h11, 1,1,8'h02,8'h22));
        @(negedge clk);
        chk("tie2_idle", {63'd0, busy}, 64'd0);
        next_cycle();
        @(negedge clk);
        chk("tie2_first", {62'd0, i2c_gnt, host_gnt}, RR ? 64'b01 : 64'b10);
        next_cycle();
        drive(I(RR,1,8'h01,8'h11, !RR,1,8'h02,8'h22));
        @(negedge clk);
        chk("tie2_gap", {61'd0, i2c_gnt, host_gnt, busy}, 64'd0);
        next_cycle();
        @(negedge clk);
        chk("tie2_second", {52'd0, i2c_gnt, host_gnt, mem_addr, owner, busy},
            RR ? {52'd0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1} : {52'd0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1});
        next_cycle();
        drive(I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00));

        // Reset while a host read is pending.
        next_cycle();
        drive(I(0,0,8'h00,8'h00, 1,0,8'h12,8'h00));
        @(negedge clk); next_cycle();
        @(negedge clk);
        chk("rst_host_gnt", {63'd0, host_gnt}, 64'd1);
        next_cycle();
        drive(I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00));
        @(negedge clk);
        chk("rst_pending", {62'd0, busy, host_rvalid}, 64'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_zero", 64'(sample()), 64'(0));
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_no_rvalid", {53'd0, i2c_rvalid, host_rvalid, host_rdata, busy}, 64'd0);
            next_cycle();
        end
        drive(I(1,1,8'h09,8'h5A, 1,1,8'h0A,8'h6B));
        @(negedge clk); next_cycle();
        @(negedge clk);
        chk("rst_first_tie_i2c", {44'd0, i2c_gnt, host_gnt, mem_en, mem_we, mem_addr, mem_wdata},
            {44'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h09, 8'h5A});
        next_cycle();
        drive(I(0,0,8'h00,8'h00, 0,0,8'h00,8'h00));
        next_cycle();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
